// File: rtl/intersection_phase_scheduler.sv
// Two-way intersection sequencer: green/yellow/all-red phases with pedestrian walk and manual override.
// State updates one clk after a tick or override change; lamps decode the phase register combinationally.
module intersection_phase_scheduler #(
   parameter int TICK_DIV = 100_000_000,
   parameter int GREEN_T  = 9,
   parameter int YELLOW_T = 3,
   parameter int ALLRED_T = 1,
   parameter int PED_T    = 3,
   parameter int WALK_T   = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       manual_override,
   input  logic [1:0] manual_state,
   input  logic       ped_req,
   output logic       ns_r,
   output logic       ns_y,
   output logic       ns_g,
   output logic       ew_r,
   output logic       ew_y,
   output logic       ew_g,
   output logic       ped_walk,
   output logic [2:0] phase,
   output logic [3:0] time_remaining
);

   typedef enum logic [2:0] {
      NS_G   = 3'd0,
      NS_Y   = 3'd1,
      AR_A   = 3'd2,
      EW_G   = 3'd3,
      EW_Y   = 3'd4,
      AR_B   = 3'd5,
      MANUAL = 3'd6
   } phase_t;

   localparam int DIV_W = $clog2(TICK_DIV);

   phase_t           phase_q, phase_d, succ;
   logic [3:0]       tr_q, tr_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             ped_pending, pend_d, pend_clr;
   logic             walk_d;
   logic [1:0]       mstate_q;
   logic             tick;

   assign tick           = (div_q == DIV_W'(TICK_DIV - 1));
   assign phase          = phase_q;
   assign time_remaining = tr_q;

   function automatic logic [3:0] dur(input phase_t p);
      case (p)
         NS_G, EW_G: dur = 4'(GREEN_T);
         NS_Y, EW_Y: dur = 4'(YELLOW_T);
         default:    dur = 4'(ALLRED_T);
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_q     <= AR_B;
         tr_q        <= 4'(ALLRED_T);
         div_q       <= '0;
         ped_pending <= 1'b0;
         ped_walk    <= 1'b0;
         mstate_q    <= 2'b00;
      end else begin
         phase_q     <= phase_d;
         tr_q        <= tr_d;
         div_q       <= div_d;
         ped_pending <= pend_d;
         ped_walk    <= walk_d;
         mstate_q    <= manual_state;
      end
   end

   always_comb begin
      phase_d  = phase_q;
      tr_d     = tr_q;
      walk_d   = ped_walk;
      div_d    = div_q + DIV_W'(1);
      pend_clr = 1'b0;
      case (phase_q)
         NS_G:    succ = NS_Y;
         NS_Y:    succ = AR_A;
         AR_A:    succ = EW_G;
         EW_G:    succ = EW_Y;
         EW_Y:    succ = AR_B;
         default: succ = NS_G;
      endcase

      if (manual_override) begin
         phase_d = MANUAL;
         tr_d    = 4'd0;
         walk_d  = 1'b0;
         div_d   = '0;
      end else if (phase_q == MANUAL) begin
         // Leaving override always restarts from a plain all-red with a fresh divider.
         phase_d = AR_B;
         tr_d    = 4'(ALLRED_T);
         div_d   = '0;
      end else if (tick) begin
         div_d = '0;
         if (tr_q == 4'd1) begin
            phase_d = succ;
            tr_d    = dur(succ);
            walk_d  = 1'b0;
            if ((succ == AR_A || succ == AR_B) && ped_pending) begin
               tr_d     = 4'(WALK_T);
               walk_d   = 1'b1;
               pend_clr = 1'b1;
            end
         end else if ((phase_q == NS_G || phase_q == EW_G) && ped_pending &&
                      tr_q > 4'(PED_T)) begin
            tr_d = 4'(PED_T);
         end else begin
            tr_d = tr_q - 4'd1;
         end
      end

      // A new press wins over the clear from walk service on the same edge.
      pend_d = ped_req | (ped_pending & ~pend_clr);
   end

   always_comb begin
      ns_r = 1'b1;
      ns_y = 1'b0;
      ns_g = 1'b0;
      ew_r = 1'b1;
      ew_y = 1'b0;
      ew_g = 1'b0;
      case (phase_q)
         NS_G: begin ns_r = 1'b0; ns_g = 1'b1; end
         NS_Y: begin ns_r = 1'b0; ns_y = 1'b1; end
         EW_G: begin ew_r = 1'b0; ew_g = 1'b1; end
         EW_Y: begin ew_r = 1'b0; ew_y = 1'b1; end
         MANUAL: begin
            case (mstate_q)
               2'b01:   begin ns_r = 1'b0; ns_g = 1'b1; end
               2'b10:   begin ew_r = 1'b0; ew_g = 1'b1; end
               2'b11:   begin ns_r = 1'b0; ns_y = 1'b1; ew_r = 1'b0; ew_y = 1'b1; end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Bench for intersection_phase_scheduler with short timing parameters.
// Expected phase/time/lamp states are queued per scenario and compared at the following negedge.
module tb_intersection_phase_scheduler;

   logic       clk;
   logic       reset;
   logic       manual_override;
   logic [1:0] manual_state;
   logic       ped_req;
   logic       ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, ped_walk;
   logic [2:0] phase;
   logic [3:0] time_remaining;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         gap;
      logic [2:0] ph;
      logic [3:0] tr;
      logic       walk;
      logic       pend;
      logic [1:0] ms;
   } exp_t;

   exp_t sb[$];

   intersection_phase_scheduler #(
      .TICK_DIV(4), .GREEN_T(5), .YELLOW_T(2), .ALLRED_T(1), .PED_T(2), .WALK_T(3)
   ) dut (
      .clk(clk), .reset(reset), .manual_override(manual_override),
      .manual_state(manual_state), .ped_req(ped_req),
      .ns_r(ns_r), .ns_y(ns_y), .ns_g(ns_g), .ew_r(ew_r), .ew_y(ew_y), .ew_g(ew_g),
      .ped_walk(ped_walk), .phase(phase), .time_remaining(time_remaining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [5:0] lamps_of(input logic [2:0] ph, input logic [1:0] ms);
      case (ph)
         3'd0: lamps_of = 6'b001100;
         3'd1: lamps_of = 6'b010100;
         3'd3: lamps_of = 6'b100001;
         3'd4: lamps_of = 6'b100010;
         3'd6: begin
            case (ms)
               2'd1:    lamps_of = 6'b001100;
               2'd2:    lamps_of = 6'b100001;
               2'd3:    lamps_of = 6'b010010;
               default: lamps_of = 6'b100100;
            endcase
         end
         default: lamps_of = 6'b100100;
      endcase
   endfunction

   function automatic void push(input int gap, input int ph, input int tr,
                                input logic walk, input logic pend, input int ms = 0);
      exp_t e;
      e.gap  = gap;
      e.ph   = 3'(ph);
      e.tr   = 4'(tr);
      e.walk = walk;
      e.pend = pend;
      e.ms   = 2'(ms);
      sb.push_back(e);
   endfunction

   function automatic logic [5:0] lamps_now();
      lamps_now = {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g};
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      manual_override = 1'b0;
      manual_state = 2'b00;
      ped_req = 1'b0;
      #12;
      checks += 4;
      if (phase !== 3'd5) begin errors++; $display("FAIL reset phase: got %0d want 5", phase); end
      if (time_remaining !== 4'd1) begin errors++; $display("FAIL reset tr: got %0d want 1", time_remaining); end
      if (lamps_now() !== 6'b100100) begin errors++; $display("FAIL reset lamps: got %b want 100100", lamps_now()); end
      if (ped_walk !== 1'b0) begin errors++; $display("FAIL reset walk: got %b want 0", ped_walk); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks += 2;
      if (phase !== 3'd5) begin errors++; $display("FAIL release phase: got %0d want 5", phase); end
      if (time_remaining !== 4'd1) begin errors++; $display("FAIL release tr: got %0d want 1", time_remaining); end
      @(negedge clk);
   endtask

   task automatic test_auto_cycle();
      exp_t e;
      // The release negedge has been consumed, so the first tick is 3 edges away.
      push(3, 0, 5, 0, 0);
      push(4, 0, 4, 0, 0); push(4, 0, 3, 0, 0); push(4, 0, 2, 0, 0); push(4, 0, 1, 0, 0);
      push(4, 1, 2, 0, 0); push(4, 1, 1, 0, 0); push(4, 2, 1, 0, 0);
      push(4, 3, 5, 0, 0); push(4, 3, 4, 0, 0); push(4, 3, 3, 0, 0); push(4, 3, 2, 0, 0);
      push(4, 3, 1, 0, 0); push(4, 4, 2, 0, 0); push(4, 4, 1, 0, 0); push(4, 5, 1, 0, 0);
      push(4, 0, 5, 0, 0);
      while (sb.size() != 0) begin
         e = sb.pop_front();
         repeat (e.gap) @(posedge clk);
         @(negedge clk);
         checks += 5;
         if (phase !== e.ph) begin errors++; $display("FAIL auto phase: got %0d want %0d", phase, e.ph); end
         if (time_remaining !== e.tr) begin errors++; $display("FAIL auto tr: got %0d want %0d", time_remaining, e.tr); end
         if (lamps_now() !== lamps_of(e.ph, e.ms)) begin errors++; $display("FAIL auto lamps: got %b want %b", lamps_now(), lamps_of(e.ph, e.ms)); end
         if (ped_walk !== e.walk) begin errors++; $display("FAIL auto walk: got %b want %b", ped_walk, e.walk); end
         if (dut.ped_pending !== e.pend) begin errors++; $display("FAIL auto pending: got %b want %b", dut.ped_pending, e.pend); end
      end
   endtask

   task automatic test_ped_ns_cutdown();
      exp_t e;
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0) begin
            ped_req = 1'b1;
            push(4, 0, 2, 0, 1);
         end else begin
            ped_req = 1'b0;
            push(4, 0, 1, 0, 1); push(4, 1, 2, 0, 1); push(4, 1, 1, 0, 1);
            push(4, 2, 3, 1, 0); push(4, 2, 2, 1, 0); push(4, 2, 1, 1, 0);
            push(4, 3, 5, 0, 0);
         end
         while (sb.size() != 0) begin
            e = sb.pop_front();
            repeat (e.gap) @(posedge clk);
            @(negedge clk);
            checks += 5;
            if (phase !== e.ph) begin errors++; $display("FAIL ped_ns phase: got %0d want %0d", phase, e.ph); end
            if (time_remaining !== e.tr) begin errors++; $display("FAIL ped_ns tr: got %0d want %0d", time_remaining, e.tr); end
            if (lamps_now() !== lamps_of(e.ph, e.ms)) begin errors++; $display("FAIL ped_ns lamps: got %b want %b", lamps_now(), lamps_of(e.ph, e.ms)); end
            if (ped_walk !== e.walk) begin errors++; $display("FAIL ped_ns walk: got %b want %b", ped_walk, e.walk); end
            if (dut.ped_pending !== e.pend) begin errors++; $display("FAIL ped_ns pending: got %b want %b", dut.ped_pending, e.pend); end
         end
      end
   endtask

   task automatic test_ped_ew_late();
      exp_t e;
      for (int pass = 0; pass < 3; pass++) begin
         if (pass == 0) begin
            push(4, 3, 4, 0, 0); push(4, 3, 3, 0, 0); push(4, 3, 2, 0, 0);
         end else if (pass == 1) begin
            ped_req = 1'b1;
            push(4, 3, 1, 0, 1);
         end else begin
            ped_req = 1'b0;
            push(4, 4, 2, 0, 1); push(4, 4, 1, 0, 1);
            push(4, 5, 3, 1, 0); push(4, 5, 2, 1, 0); push(4, 5, 1, 1, 0);
            push(4, 0, 5, 0, 0);
         end
         while (sb.size() != 0) begin
            e = sb.pop_front();
            repeat (e.gap) @(posedge clk);
            @(negedge clk);
            checks += 5;
            if (phase !== e.ph) begin errors++; $display("FAIL ped_ew phase: got %0d want %0d", phase, e.ph); end
            if (time_remaining !== e.tr) begin errors++; $display("FAIL ped_ew tr: got %0d want %0d", time_remaining, e.tr); end
            if (lamps_now() !== lamps_of(e.ph, e.ms)) begin errors++; $display("FAIL ped_ew lamps: got %b want %b", lamps_now(), lamps_of(e.ph, e.ms)); end
            if (ped_walk !== e.walk) begin errors++; $display("FAIL ped_ew walk: got %b want %b", ped_walk, e.walk); end
            if (dut.ped_pending !== e.pend) begin errors++; $display("FAIL ped_ew pending: got %b want %b", dut.ped_pending, e.pend); end
         end
      end
   endtask

   task automatic test_override();
      exp_t e;
      for (int pass = 0; pass < 5; pass++) begin
         case (pass)
            0: begin
               push(4, 0, 4, 0, 0); push(4, 0, 3, 0, 0); push(4, 0, 2, 0, 0); push(4, 0, 1, 0, 0);
               push(4, 1, 2, 0, 0); push(4, 1, 1, 0, 0); push(4, 2, 1, 0, 0);
               push(4, 3, 5, 0, 0); push(4, 3, 4, 0, 0);
            end
            1: begin
               manual_override = 1'b1;
               manual_state = 2'b01;
               push(1, 6, 0, 0, 0, 1);
            end
            2: begin
               manual_state = 2'b11;
               ped_req = 1'b1;
               push(1, 6, 0, 0, 1, 3);
            end
            3: begin
               ped_req = 1'b0;
               push(8, 6, 0, 0, 1, 3);
            end
            default: begin
               manual_override = 1'b0;
               push(1, 5, 1, 0, 1); push(4, 0, 5, 0, 1); push(4, 0, 2, 0, 1);
               push(4, 0, 1, 0, 1); push(4, 1, 2, 0, 1);
            end
         endcase
         while (sb.size() != 0) begin
            e = sb.pop_front();
            repeat (e.gap) @(posedge clk);
            @(negedge clk);
            checks += 5;
            if (phase !== e.ph) begin errors++; $display("FAIL override phase: got %0d want %0d", phase, e.ph); end
            if (time_remaining !== e.tr) begin errors++; $display("FAIL override tr: got %0d want %0d", time_remaining, e.tr); end
            if (lamps_now() !== lamps_of(e.ph, e.ms)) begin errors++; $display("FAIL override lamps: got %b want %b", lamps_now(), lamps_of(e.ph, e.ms)); end
            if (ped_walk !== e.walk) begin errors++; $display("FAIL override walk: got %b want %b", ped_walk, e.walk); end
            if (dut.ped_pending !== e.pend) begin errors++; $display("FAIL override pending: got %b want %b", dut.ped_pending, e.pend); end
         end
      end
   endtask

   task automatic test_async_reset();
      // Sitting in NS_Y with a pending request, clk low: reset must act without an edge.
      #1 reset = 1'b0;
      #1;
      checks += 5;
      if (phase !== 3'd5) begin errors++; $display("FAIL async_reset phase: got %0d want 5", phase); end
      if (time_remaining !== 4'd1) begin errors++; $display("FAIL async_reset tr: got %0d want 1", time_remaining); end
      if (lamps_now() !== 6'b100100) begin errors++; $display("FAIL async_reset lamps: got %b want 100100", lamps_now()); end
      if (ped_walk !== 1'b0) begin errors++; $display("FAIL async_reset walk: got %b want 0", ped_walk); end
      if (dut.ped_pending !== 1'b0) begin errors++; $display("FAIL async_reset pending: got %b want 0", dut.ped_pending); end
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_auto_cycle();
      test_ped_ns_cutdown();
      test_ped_ew_late();
      test_override();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
